// File: rtl/io_pkg.sv
// Shared definitions for the board input path: debounce FSM encodings and
// the MMIO addresses served by the switch read block.
package io_pkg;

  // Legacy state encodings, kept so existing decode logic can compare raw bits.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  typedef enum logic [1:0] {
    DB_IDLE      = ST_IDLE,
    DB_PRESS_CHK = ST_PRESS_CHK,
    DB_HELD      = ST_HELD,
    DB_REL_CHK   = ST_REL_CHK
  } db_state_t;

  // MMIO map of the input block.
  localparam logic [31:0] CONFIRM_ADDR = 32'hffff_ff00;
  localparam logic [31:0] SW_ADDR      = 32'hffff_fff1; // switches [7:0]
  localparam logic [31:0] SW_HI_ADDR   = 32'hffff_fff2; // switches [15:8]

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, parameterized width.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two register stages; the first may go metastable, the second is safe to use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Board input conditioner: synchronizes switches and the confirm button,
// debounces the button, and keeps a sticky confirmation flag for the CPU.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic [15:0] sw_raw,
  input  logic        confirm_ack,
  output logic [15:0] sw_sync,
  output logic        confirmation,
  output logic        btn_level,
  output logic        press_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [16:0]   sync_q;
  logic          btn_s;
  db_state_t     state;
  logic [CW-1:0] cnt;
  logic          press_set;

  sync_2ff #(.WIDTH(17)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({btn_raw, sw_raw}),
    .q   (sync_q)
  );

  assign sw_sync = sync_q[15:0];
  assign btn_s   = sync_q[16];

  // Press accepted on the edge that moves PRESS_CHK into HELD.
  always_comb begin
    press_set = (state == DB_PRESS_CHK) && btn_s && (cnt == CNT_LAST);
  end

  // Debounce FSM: both edges need DEBOUNCE_CYCLES stable samples; counter
  // is cleared on every state entry so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= DB_IDLE;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= press_set;
      unique case (state)
        DB_IDLE: begin
          if (btn_s) begin
            state <= DB_PRESS_CHK;
            cnt   <= '0;
          end
        end
        DB_PRESS_CHK: begin
          if (!btn_s) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_HELD: begin
          if (!btn_s) begin
            state <= DB_REL_CHK;
            cnt   <= '0;
          end
        end
        DB_REL_CHK: begin
          if (btn_s) begin
            state <= DB_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Debounced level covers the whole held period including release checking.
  always_comb begin
    btn_level = (state == DB_HELD) || (state == DB_REL_CHK);
  end

  // Sticky confirmation: set together with press_pulse and held through the
  // pulse cycle, so an ack landing on the pulse cannot swallow the press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      confirmation <= 1'b0;
    end else if (press_set || press_pulse) begin
      confirmation <= 1'b1;
    end else if (confirm_ack) begin
      confirmation <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_io_input_conditioner;

  logic        clk;
  logic        rst;
  logic        btn_raw;
  logic [15:0] sw_raw;
  logic        confirm_ack;
  logic [15:0] sw_sync;
  logic        confirmation;
  logic        btn_level;
  logic        press_pulse;

  int unsigned n_cmp;
  int unsigned n_bad;

  io_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .sw_raw       (sw_raw),
    .confirm_ack  (confirm_ack),
    .sw_sync      (sw_sync),
    .confirmation (confirmation),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle; inputs set afterwards apply to the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_level"}, {31'd0, btn_level}, 32'd0);
    check({tag, "_pulse"}, {31'd0, press_pulse}, 32'd0);
  endtask

  // Raise btn_raw now; level and pulse must appear on the 7th edge after.
  task automatic press_and_check(input string tag);
    btn_raw = 1'b1;
    for (int unsigned i = 1; i <= 6; i++) begin
      step();
      check_idle_outputs({tag, "_wait"});
    end
    step();
    check({tag, "_level"}, {31'd0, btn_level}, 32'd1);
    check({tag, "_pulse"}, {31'd0, press_pulse}, 32'd1);
    check({tag, "_conf"}, {31'd0, confirmation}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    btn_raw = 1'b0;
    sw_raw = 16'hFFFF;
    confirm_ack = 1'b0;

    // Reset state: sw_raw non-zero must not leak through while in reset.
    steps(3);
    check("rst_sw", {16'd0, sw_sync}, 32'd0);
    check("rst_conf", {31'd0, confirmation}, 32'd0);
    check_idle_outputs("rst");
    sw_raw = 16'h0000;
    rst = 1'b1;
    steps(3);

    // Ack with nothing pending does nothing.
    confirm_ack = 1'b1;
    step();
    confirm_ack = 1'b0;
    check("ack_idle_conf", {31'd0, confirmation}, 32'd0);

    // Clean press.
    press_and_check("press1");
    step();
    check("press1_pulse_end", {31'd0, press_pulse}, 32'd0);
    check("press1_hold_lvl", {31'd0, btn_level}, 32'd1);

    // 3-cycle gap while held is filtered out.
    btn_raw = 1'b0;
    steps(3);
    btn_raw = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      check("gap_level", {31'd0, btn_level}, 32'd1);
      check("gap_pulse", {31'd0, press_pulse}, 32'd0);
    end

    // Release; flag stays set until acked.
    btn_raw = 1'b0;
    steps(10);
    check("rel_level", {31'd0, btn_level}, 32'd0);
    check("rel_conf", {31'd0, confirmation}, 32'd1);

    // Ack at an idle time clears the flag next cycle.
    confirm_ack = 1'b1;
    step();
    confirm_ack = 1'b0;
    check("ack_clear", {31'd0, confirmation}, 32'd0);
    step();
    check("ack_stay", {31'd0, confirmation}, 32'd0);

    // 3-cycle and 4-cycle pulses are both too short.
    for (int unsigned len = 3; len <= 4; len++) begin
      btn_raw = 1'b1;
      steps(len);
      btn_raw = 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
        step();
        check_idle_outputs("short");
      end
      check("short_conf", {31'd0, confirmation}, 32'd0);
    end

    // Second press sets the flag again; ack during the pulse cycle loses to it.
    press_and_check("press2");
    confirm_ack = 1'b1;
    step();
    confirm_ack = 1'b0;
    check("coinc_conf", {31'd0, confirmation}, 32'd1);
    check("coinc_pulse", {31'd0, press_pulse}, 32'd0);
    confirm_ack = 1'b1;
    step();
    confirm_ack = 1'b0;
    check("ack2_clear", {31'd0, confirmation}, 32'd0);
    btn_raw = 1'b0;
    steps(10);

    // Repeated presses without an ack keep the flag at 1.
    press_and_check("press3");
    btn_raw = 1'b0;
    steps(10);
    press_and_check("press4");
    btn_raw = 1'b0;
    steps(10);
    check("repeat_conf", {31'd0, confirmation}, 32'd1);

    // Switch path: two-cycle latency, no filtering.
    sw_raw = 16'hA5C3;
    step();
    check("sw_lat1", {16'd0, sw_sync}, 32'h0000);
    step();
    check("sw_lat2", {16'd0, sw_sync}, 32'hA5C3);
    sw_raw = 16'h5A3C;
    step();
    check("sw_hold", {16'd0, sw_sync}, 32'hA5C3);
    step();
    check("sw_new", {16'd0, sw_sync}, 32'h5A3C);

    // Reset in PRESS_CHK aborts without a pulse and clears the pending flag.
    btn_raw = 1'b1;
    steps(4);
    check("pre_rst_level", {31'd0, btn_level}, 32'd0);
    rst = 1'b0;
    step();
    check("mid_rst_sw", {16'd0, sw_sync}, 32'd0);
    check("mid_rst_conf", {31'd0, confirmation}, 32'd0);
    check_idle_outputs("mid_rst");
    rst = 1'b1;

    // Button still held after release from reset counts as a new press.
    press_and_check("post_rst");
    step();
    check("post_rst_pulse_end", {31'd0, press_pulse}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
